// File: rtl/ps2_pkg.sv
// Shared scan-code constants, key codes, direction encoding and decoder state
// type for the PS/2 paddle controller.
package ps2_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;

   localparam logic [7:0] KC_W    = 8'h01;
   localparam logic [7:0] KC_S    = 8'h02;
   localparam logic [7:0] KC_UP   = 8'h03;
   localparam logic [7:0] KC_DOWN = 8'h04;

   localparam logic [1:0] DIR_NONE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_EXT       = 2'd1,
      ST_BREAK     = 2'd2,
      ST_EXT_BREAK = 2'd3
   } dec_state_e;

   // Keyboard housekeeping bytes that never carry key information.
   function automatic logic is_ctrl(input logic [7:0] b);
      case (b)
         8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF, 8'h00, 8'hE1: return 1'b1;
         default:                                          return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] make_code(input logic [7:0] b);
      case (b)
         SC_W:    return KC_W;
         SC_S:    return KC_S;
         SC_UP:   return KC_UP;
         SC_DOWN: return KC_DOWN;
         default: return b;
      endcase
   endfunction

endpackage

// File: rtl/paddle_pacer.sv
// Per-player direction arbitration between up/down holds and fixed-rate
// step pulse generation with a reloading down-counter.
module paddle_pacer
   import ps2_pkg::*;
#(
   parameter int MOVE_PERIOD = 500000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       up_held_i,
   input  logic       down_held_i,
   input  logic       last_up_i,
   output logic [1:0] dir_o,
   output logic       step_o
);

   localparam int             CW   = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
   localparam logic [CW-1:0]  LOAD = CW'(MOVE_PERIOD - 1);

   logic [1:0]    dir_q, dir_d;
   logic [1:0]    prev_dir_q, prev_dir_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          step_q, step_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dir_q      <= DIR_NONE;
         prev_dir_q <= DIR_NONE;
         cnt_q      <= '0;
         step_q     <= 1'b0;
      end else begin
         dir_q      <= dir_d;
         prev_dir_q <= prev_dir_d;
         cnt_q      <= cnt_d;
         step_q     <= step_d;
      end
   end

   always_comb begin
      dir_d      = DIR_NONE;
      prev_dir_d = dir_q;
      cnt_d      = cnt_q;
      step_d     = 1'b0;

      if (up_held_i && down_held_i) dir_d = last_up_i ? DIR_UP : DIR_DOWN;
      else if (up_held_i)           dir_d = DIR_UP;
      else if (down_held_i)         dir_d = DIR_DOWN;

      // A fresh or reversed direction steps at once; a steady one steps on terminal count.
      if (dir_q == DIR_NONE) begin
         cnt_d = '0;
      end else if (dir_q != prev_dir_q) begin
         step_d = 1'b1;
         cnt_d  = LOAD;
      end else if (cnt_q == '0) begin
         step_d = 1'b1;
         cnt_d  = LOAD;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign dir_o  = dir_q;
   assign step_o = step_q;

endmodule

// File: rtl/ps2_paddle_ctrl.sv
// Decodes the PS/2 byte stream into held paddle keys and drives two paddle
// pacers; also reports every decoded key press.
//
// state        | meaning
// ST_IDLE      | no prefix pending; data byte is a make
// ST_EXT       | E0 seen; data byte is an extended make, F0 moves to ST_EXT_BREAK
// ST_BREAK     | F0 seen; data byte is a break
// ST_EXT_BREAK | E0 F0 seen; data byte is an extended break
module ps2_paddle_ctrl
   import ps2_pkg::*;
#(
   parameter int MOVE_PERIOD    = 500000,
   parameter int PREFIX_TIMEOUT = 50000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   output logic [1:0] p1_dir,
   output logic [1:0] p2_dir,
   output logic       p1_step,
   output logic       p2_step,
   output logic       key_event,
   output logic [7:0] key_code
);

   localparam int            TW       = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(PREFIX_TIMEOUT - 1);

   dec_state_e    state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [3:0]    held_q, held_d;
   logic [1:0]    last_up_q, last_up_d;
   logic          key_event_q, key_event_d;
   logic [7:0]    key_code_q, key_code_d;

   logic          key_hit;
   logic [1:0]    key_idx;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tmo_q       <= '0;
         held_q      <= '0;
         last_up_q   <= '0;
         key_event_q <= 1'b0;
         key_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         held_q      <= held_d;
         last_up_q   <= last_up_d;
         key_event_q <= key_event_d;
         key_code_q  <= key_code_d;
      end
   end

   // Key index: bit 1 selects the player, bit 0 selects down.
   always_comb begin
      key_hit = 1'b1;
      key_idx = 2'd0;
      case (received_data)
         SC_W:    key_idx = 2'd0;
         SC_S:    key_idx = 2'd1;
         SC_UP:   key_idx = 2'd2;
         SC_DOWN: key_idx = 2'd3;
         default: key_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      held_d      = held_q;
      last_up_d   = last_up_q;
      key_event_d = 1'b0;
      key_code_d  = key_code_q;

      if (received_data_en) begin
         tmo_d = TMO_LOAD;
         if (is_ctrl(received_data)) begin
            state_d = ST_IDLE;
         end else if (received_data == SC_EXT) begin
            state_d = ST_EXT;
         end else if (received_data == SC_BREAK) begin
            state_d = (state_q == ST_EXT || state_q == ST_EXT_BREAK) ? ST_EXT_BREAK : ST_BREAK;
         end else begin
            state_d = ST_IDLE;
            if (state_q == ST_BREAK || state_q == ST_EXT_BREAK) begin
               if (key_hit) held_d[key_idx] = 1'b0;
            end else begin
               key_event_d = 1'b1;
               key_code_d  = make_code(received_data);
               // Typematic repeats of a held key must not disturb last-pressed.
               if (key_hit && !held_q[key_idx]) begin
                  held_d[key_idx]         = 1'b1;
                  last_up_d[key_idx[1]]   = ~key_idx[0];
               end
            end
         end
      end else if (state_q != ST_IDLE) begin
         if (tmo_q == '0) state_d = ST_IDLE;
         else             tmo_d   = tmo_q - 1'b1;
      end
   end

   // Pacers see next-state holds so direction lands on the same edge as key_event.
   paddle_pacer #(.MOVE_PERIOD(MOVE_PERIOD)) u_pacer_p1 (
      .clk_i       (CLOCK_50),
      .rst_i       (reset),
      .up_held_i   (held_d[0]),
      .down_held_i (held_d[1]),
      .last_up_i   (last_up_d[0]),
      .dir_o       (p1_dir),
      .step_o      (p1_step)
   );

   paddle_pacer #(.MOVE_PERIOD(MOVE_PERIOD)) u_pacer_p2 (
      .clk_i       (CLOCK_50),
      .rst_i       (reset),
      .up_held_i   (held_d[2]),
      .down_held_i (held_d[3]),
      .last_up_i   (last_up_d[1]),
      .dir_o       (p2_dir),
      .step_o      (p2_step)
   );

   assign key_event = key_event_q;
   assign key_code  = key_code_q;

endmodule

// File: tb/tb_ps2_paddle_ctrl.sv
// Self-checking bench for ps2_paddle_ctrl: directed scenarios followed by a
// randomized byte stream, all checked every cycle against a behavioural model.
module tb_ps2_paddle_ctrl;

   localparam int MP = 4;
   localparam int PT = 8;

   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b1;
   logic [7:0] received_data    = 8'h00;
   logic       received_data_en = 1'b0;
   logic [1:0] p1_dir, p2_dir;
   logic       p1_step, p2_step, key_event;
   logic [7:0] key_code;

   ps2_paddle_ctrl #(.MOVE_PERIOD(MP), .PREFIX_TIMEOUT(PT)) dut (
      .CLOCK_50         (CLOCK_50),
      .reset            (reset),
      .received_data    (received_data),
      .received_data_en (received_data_en),
      .p1_dir           (p1_dir),
      .p2_dir           (p2_dir),
      .p1_step          (p1_step),
      .p2_step          (p2_step),
      .key_event        (key_event),
      .key_code         (key_code)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int total = 0;
   int bad   = 0;

   // Behavioural model: held-key set, last-pressed per player, pending break
   // flag, and an absolute cycle schedule for the next step of each player.
   int         cyc = 0;
   int         m_last_strobe;
   bit         m_brk;
   bit         m_held [4];
   bit         m_last_up [2];
   logic [1:0] m_dir [2];
   int         m_next [2];
   bit         m_step [2];
   bit         m_kev;
   logic [7:0] m_kcode;

   logic [7:0] keys [4] = '{8'h1D, 8'h1B, 8'h75, 8'h72};
   logic [7:0] ctls [7] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF, 8'h00, 8'hE1};

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [1:0] arb(input bit u, input bit d, input bit lu);
      if (u && d) return lu ? 2'b01 : 2'b10;
      if (u)      return 2'b01;
      if (d)      return 2'b10;
      return 2'b00;
   endfunction

   function automatic int key_of(input logic [7:0] b);
      for (int i = 0; i < 4; i++) if (keys[i] == b) return i;
      return -1;
   endfunction

   function automatic bit is_ctl(input logic [7:0] b);
      for (int i = 0; i < 7; i++) if (ctls[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_last_strobe = -1000;
      m_brk   = 1'b0;
      m_kev   = 1'b0;
      m_kcode = 8'h00;
      for (int i = 0; i < 4; i++) m_held[i] = 1'b0;
      for (int p = 0; p < 2; p++) begin
         m_last_up[p] = 1'b0;
         m_dir[p]     = 2'b00;
         m_next[p]    = -1;
         m_step[p]    = 1'b0;
      end
   endtask

   task automatic model_edge(input bit en, input logic [7:0] d);
      int         k;
      logic [1:0] nd;
      cyc++;
      m_kev = 1'b0;
      for (int p = 0; p < 2; p++) begin
         m_step[p] = (m_dir[p] != 2'b00) && (cyc == m_next[p]);
         if (m_step[p]) m_next[p] += MP;
      end
      if (en) begin
         if (cyc - m_last_strobe > PT) m_brk = 1'b0;
         m_last_strobe = cyc;
         k = key_of(d);
         if (is_ctl(d))        m_brk = 1'b0;
         else if (d == 8'hE0)  m_brk = 1'b0;
         else if (d == 8'hF0)  m_brk = 1'b1;
         else begin
            if (m_brk) begin
               if (k >= 0) m_held[k] = 1'b0;
            end else begin
               m_kev   = 1'b1;
               m_kcode = (k >= 0) ? 8'(k + 1) : d;
               if (k >= 0 && !m_held[k]) begin
                  m_held[k]        = 1'b1;
                  m_last_up[k / 2] = (k % 2 == 0);
               end
            end
            m_brk = 1'b0;
         end
      end
      for (int p = 0; p < 2; p++) begin
         nd = arb(m_held[2*p], m_held[2*p+1], m_last_up[p]);
         if (nd != m_dir[p]) begin
            m_dir[p]  = nd;
            m_next[p] = (nd != 2'b00) ? cyc + 1 : -1;
         end
      end
   endtask

   task automatic check_model();
      chk("m_p1_dir",    8'(p1_dir),    8'(m_dir[0]));
      chk("m_p2_dir",    8'(p2_dir),    8'(m_dir[1]));
      chk("m_p1_step",   8'(p1_step),   8'(m_step[0]));
      chk("m_p2_step",   8'(p2_step),   8'(m_step[1]));
      chk("m_key_event", 8'(key_event), 8'(m_kev));
      chk("m_key_code",  key_code,      m_kcode);
   endtask

   task automatic cyc_step(input bit en, input logic [7:0] d);
      received_data_en = en;
      received_data    = d;
      @(posedge CLOCK_50);
      model_edge(en, d);
      @(negedge CLOCK_50);
      check_model();
   endtask

   task automatic send(input logic [7:0] d);
      cyc_step(1'b1, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc_step(1'b0, 8'h00);
   endtask

   initial begin
      int n;
      int r;
      int gap;
      logic [7:0] b;

      model_reset();
      repeat (3) @(negedge CLOCK_50);
      chk("rst_p1_dir", 8'(p1_dir), 8'h00);
      chk("rst_p2_dir", 8'(p2_dir), 8'h00);
      chk("rst_step",   8'({p1_step, p2_step}), 8'h00);
      chk("rst_kev",    8'(key_event), 8'h00);
      chk("rst_kcode",  key_code, 8'h00);
      reset = 1'b0;
      idle(2);

      // W press: event and dir at N+1, first step at N+2, then every MP cycles.
      send(8'h1D);
      chk("t1_kev",    8'(key_event), 8'h01);
      chk("t1_kcode",  key_code, 8'h01);
      chk("t1_p1_dir", 8'(p1_dir), 8'h01);
      chk("t1_step_n1", 8'(p1_step), 8'h00);
      idle(1);
      chk("t1_step_n2", 8'(p1_step), 8'h01);
      chk("t1_kev_n2",  8'(key_event), 8'h00);
      idle(3);
      chk("t1_step_n5", 8'(p1_step), 8'h00);
      idle(1);
      chk("t1_step_n6", 8'(p1_step), 8'h01);
      idle(4);
      chk("t1_step_n10", 8'(p1_step), 8'h01);
      send(8'hF0); idle(1); send(8'h1D);
      chk("t1_rel_dir", 8'(p1_dir), 8'h00);
      chk("t1_rel_kev", 8'(key_event), 8'h00);
      idle(4);

      // Extended Up press and extended break.
      send(8'hE0); idle(2); send(8'h75);
      chk("t2_p2_dir", 8'(p2_dir), 8'h01);
      chk("t2_kcode",  key_code, 8'h03);
      idle(6);
      send(8'hE0); idle(1); send(8'hF0); idle(1); send(8'h75);
      chk("t2_brk_dir", 8'(p2_dir), 8'h00);
      chk("t2_brk_kev", 8'(key_event), 8'h00);
      n = 0;
      idle(1);
      for (int i = 0; i < 8; i++) begin
         cyc_step(1'b0, 8'h00);
         n += int'(p2_step);
      end
      chk("t2_no_steps", 8'(n), 8'h00);

      // Overlapping W/S holds, typematic W, release of winner.
      send(8'h1D); idle(5);
      send(8'h1B);
      chk("t3_down_dir", 8'(p1_dir), 8'h02);
      idle(1);
      chk("t3_down_step", 8'(p1_step), 8'h01);
      idle(2);
      send(8'h1D);
      chk("t3_typ_kev", 8'(key_event), 8'h01);
      chk("t3_typ_dir", 8'(p1_dir), 8'h02);
      idle(3); send(8'h1D); idle(4);
      send(8'hF0); idle(1); send(8'h1B);
      chk("t3_back_dir", 8'(p1_dir), 8'h01);
      idle(1);
      chk("t3_back_step", 8'(p1_step), 8'h01);
      idle(6);
      send(8'hF0); idle(1); send(8'h1D); idle(3);

      // Stale break prefix times out, so S is a make.
      send(8'hF0); idle(PT + 1); send(8'h1B);
      chk("t4_kev",   8'(key_event), 8'h01);
      chk("t4_kcode", key_code, 8'h02);
      chk("t4_dir",   8'(p1_dir), 8'h02);
      idle(3);
      // FA aborts a pending extended break; next S is a make, not a release.
      send(8'hE0); idle(1); send(8'hF0); idle(1); send(8'hFA);
      chk("t4_fa_kev",   8'(key_event), 8'h00);
      chk("t4_fa_kcode", key_code, 8'h02);
      chk("t4_fa_dir",   8'(p1_dir), 8'h02);
      idle(1); send(8'h1B);
      chk("t4_after_fa_kev", 8'(key_event), 8'h01);
      chk("t4_after_fa_dir", 8'(p1_dir), 8'h02);
      idle(2); send(8'hF0); idle(1); send(8'h1B); idle(3);

      // Asynchronous reset mid-hold with a break prefix pending.
      send(8'h72); idle(3); send(8'hF0); idle(1);
      received_data_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_p2_dir", 8'(p2_dir), 8'h00);
      chk("t5_rst_kev",    8'(key_event), 8'h00);
      chk("t5_rst_kcode",  key_code, 8'h00);
      chk("t5_rst_step",   8'({p1_step, p2_step}), 8'h00);
      model_reset();
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b0;
      idle(1);
      send(8'h72);
      chk("t5_make_dir", 8'(p2_dir), 8'h02);
      chk("t5_make_kev", 8'(key_event), 8'h01);
      idle(3); send(8'hF0); idle(1); send(8'h72); idle(3);

      // Unmapped key.
      send(8'h1C);
      chk("t6_kev",   8'(key_event), 8'h01);
      chk("t6_kcode", key_code, 8'h1C);
      chk("t6_dirs",  8'({p1_dir, p2_dir}), 8'h00);
      idle(2);

      // Randomized byte stream.
      for (int s = 0; s < 400; s++) begin
         r = int'($urandom_range(0, 15));
         if (r < 8)        b = keys[r % 4];
         else if (r < 10)  b = 8'hF0;
         else if (r == 10) b = 8'hE0;
         else if (r == 11) b = ctls[$urandom_range(0, 6)];
         else              b = 8'($urandom);
         send(b);
         gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(PT - 1, PT + 3))
                                           : int'($urandom_range(1, 6));
         idle(gap);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
